// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR block: CSR addresses, access op
// encodings, implemented bit positions and mtvec mode values.
package csr_pkg;

  // CSR addresses
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;
  localparam logic [11:0] CSR_MCYCLE  = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH = 12'hB80;

  // Access operations carried on csr_op
  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  // Implemented bit positions
  localparam int unsigned MSTATUS_MIE  = 3;
  localparam int unsigned MSTATUS_MPIE = 7;
  localparam int unsigned MIE_MEIE     = 11;
  localparam int unsigned MIP_MEIP     = 11;

  // mtvec mode field
  localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'b00;
  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'b01;

  // Cycle counter geometry
  localparam int unsigned CNT_W      = 64;
  localparam int unsigned CNT_HALF_W = 32;

  // Reserved modes (1x) collapse to direct
  function automatic logic [1:0] legal_mtvec_mode(input logic [1:0] mode);
    return mode[1] ? MTVEC_MODE_DIRECT : mode;
  endfunction

endpackage

// File: rtl/csr_counter.sv
// 64-bit free-running cycle counter with independently writable halves.
// Ports:
//   clk, rst_n      - clock, synchronous active-low reset
//   wr_lo, wr_hi    - replace the low / high half with wdata this edge
//   wdata           - write data (low 32 bits used)
//   count           - current 64-bit count
module csr_counter
  import csr_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_lo,
  input  logic             wr_hi,
  input  logic [XLEN-1:0]  wdata,
  output logic [CNT_W-1:0] count
);

  logic [CNT_HALF_W-1:0] r_lo;
  logic [CNT_HALF_W-1:0] r_hi;
  logic                  w_carry;

  assign w_carry = &r_lo;

  // A low-half write suppresses the carry into the high half for that edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lo <= '0;
      r_hi <= '0;
    end else begin
      r_lo <= wr_lo ? CNT_HALF_W'(wdata) : r_lo + CNT_HALF_W'(1);
      if (wr_hi) begin
        r_hi <= CNT_HALF_W'(wdata);
      end else if (!wr_lo) begin
        r_hi <= r_hi + CNT_HALF_W'(w_carry);
      end
    end
  end

  assign count = {r_hi, r_lo};

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file: mstatus, mie, mtvec, mepc, mcause, mip and an
// optional 64-bit mcycle counter, with trap entry / mret sequencing and
// external interrupt qualification.
// Ports:
//   clk, rst_n                 - clock, synchronous active-low reset
//   csr_op/addr/wdata          - CSR access request (RW/RS/RC)
//   csr_rdata, csr_illegal     - old value (combinational) and access fault
//   trap_valid/cause/pc, mret  - trap entry and return events
//   irq_ext                    - level external interrupt
//   trap_vector, epc           - handler address, current mepc
//   irq_pending                - interrupt enabled and pending
module csr_unit
  import csr_pkg::*;
#(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     HAS_CYCLE   = 1,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_addr,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_illegal,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            mret,
  input  logic            irq_ext,
  output logic [XLEN-1:0] trap_vector,
  output logic [XLEN-1:0] epc,
  output logic            irq_pending
);

  logic            r_mie;
  logic            r_mpie;
  logic            r_meie;
  logic            r_meip;
  logic [XLEN-1:0] r_mtvec;
  logic [XLEN-1:0] r_mepc;
  logic [XLEN-1:0] r_mcause;

  csr_op_e          w_op;
  logic [XLEN-1:0]  w_rdata;
  logic             w_impl;
  logic             w_writes;
  logic             w_illegal;
  logic             w_we;
  logic [XLEN-1:0]  w_new;
  logic             w_wr_lo;
  logic             w_wr_hi;
  logic [CNT_W-1:0] w_count;
  logic [XLEN-1:0]  w_base;

  assign w_op = csr_op_e'(csr_op);

  // Read mux and address decode
  always_comb begin
    w_rdata = '0;
    w_impl  = 1'b0;
    case (csr_addr)
      CSR_MSTATUS: begin
        w_impl                = 1'b1;
        w_rdata[MSTATUS_MIE]  = r_mie;
        w_rdata[MSTATUS_MPIE] = r_mpie;
      end
      CSR_MIE: begin
        w_impl            = 1'b1;
        w_rdata[MIE_MEIE] = r_meie;
      end
      CSR_MTVEC: begin
        w_impl  = 1'b1;
        w_rdata = r_mtvec;
      end
      CSR_MEPC: begin
        w_impl  = 1'b1;
        w_rdata = r_mepc;
      end
      CSR_MCAUSE: begin
        w_impl  = 1'b1;
        w_rdata = r_mcause;
      end
      CSR_MIP: begin
        w_impl            = 1'b1;
        w_rdata[MIP_MEIP] = r_meip;
      end
      CSR_MCYCLE: begin
        if (HAS_CYCLE != 0) begin
          w_impl  = 1'b1;
          w_rdata = XLEN'(w_count[CNT_HALF_W-1:0]);
        end
      end
      CSR_MCYCLEH: begin
        if (HAS_CYCLE != 0) begin
          w_impl  = 1'b1;
          w_rdata = XLEN'(w_count[CNT_W-1:CNT_HALF_W]);
        end
      end
      default: ;
    endcase
  end

  // Set/clear with a zero mask is a pure read, which keeps it legal on mip
  assign w_writes  = (w_op == CSR_OP_RW) || (csr_wdata != '0);
  assign w_illegal = (w_op != CSR_OP_NONE) &&
                     (!w_impl || ((csr_addr == CSR_MIP) && w_writes));
  assign w_we      = (w_op != CSR_OP_NONE) && !w_illegal && w_writes &&
                     !trap_valid && !mret;

  // Read-modify-write value
  always_comb begin
    w_new = csr_wdata;
    case (w_op)
      CSR_OP_RS: w_new = w_rdata | csr_wdata;
      CSR_OP_RC: w_new = w_rdata & ~csr_wdata;
      default:   w_new = csr_wdata;
    endcase
  end

  assign w_wr_lo = w_we && (csr_addr == CSR_MCYCLE);
  assign w_wr_hi = w_we && (csr_addr == CSR_MCYCLEH);

  // Architectural state: reset > trap > mret > CSR write
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mie    <= 1'b0;
      r_mpie   <= 1'b0;
      r_meie   <= 1'b0;
      r_meip   <= 1'b0;
      r_mtvec  <= MTVEC_RESET;
      r_mepc   <= '0;
      r_mcause <= '0;
    end else begin
      r_meip <= irq_ext;
      if (trap_valid) begin
        r_mepc   <= {trap_pc[XLEN-1:2], 2'b00};
        r_mcause <= trap_cause;
        r_mpie   <= r_mie;
        r_mie    <= 1'b0;
      end else if (mret) begin
        r_mie  <= r_mpie;
        r_mpie <= 1'b1;
      end else if (w_we) begin
        case (csr_addr)
          CSR_MSTATUS: begin
            r_mie  <= w_new[MSTATUS_MIE];
            r_mpie <= w_new[MSTATUS_MPIE];
          end
          CSR_MIE:    r_meie   <= w_new[MIE_MEIE];
          CSR_MTVEC:  r_mtvec  <= {w_new[XLEN-1:2], legal_mtvec_mode(w_new[1:0])};
          CSR_MEPC:   r_mepc   <= {w_new[XLEN-1:2], 2'b00};
          CSR_MCAUSE: r_mcause <= w_new;
          default: ;
        endcase
      end
    end
  end

  if (HAS_CYCLE != 0) begin : g_cycle
    csr_counter #(
      .XLEN (XLEN)
    ) u_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .wr_lo (w_wr_lo),
      .wr_hi (w_wr_hi),
      .wdata (w_new),
      .count (w_count)
    );
  end else begin : g_no_cycle
    assign w_count = '0;
  end

  // Handler address; vectored offset only for interrupt causes
  assign w_base = {r_mtvec[XLEN-1:2], 2'b00};

  always_comb begin
    trap_vector = w_base;
    if ((r_mtvec[1:0] == MTVEC_MODE_VECTORED) && r_mcause[XLEN-1]) begin
      trap_vector = w_base + {r_mcause[XLEN-3:0], 2'b00};
    end
  end

  assign csr_rdata   = w_rdata;
  assign csr_illegal = w_illegal;
  assign epc         = r_mepc;
  assign irq_pending = r_mie & r_meie & r_meip;

endmodule

// File: tb/tb_csr_unit.sv
// Directed self-checking bench for csr_unit.
module tb_csr_unit;

  logic        clk;
  logic        rst_n;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        trap_valid;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic        mret;
  logic        irq_ext;
  logic [31:0] trap_vector;
  logic [31:0] epc;
  logic        irq_pending;

  int n_checks = 0;
  int n_fail   = 0;

  csr_unit #(
    .XLEN        (32),
    .HAS_CYCLE   (1),
    .MTVEC_RESET (32'h0000_0203)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .csr_op      (csr_op),
    .csr_addr    (csr_addr),
    .csr_wdata   (csr_wdata),
    .csr_rdata   (csr_rdata),
    .csr_illegal (csr_illegal),
    .trap_valid  (trap_valid),
    .trap_cause  (trap_cause),
    .trap_pc     (trap_pc),
    .mret        (mret),
    .irq_ext     (irq_ext),
    .trap_vector (trap_vector),
    .epc         (epc),
    .irq_pending (irq_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One access spanning one rising edge; rdata/illegal sampled before the edge
  task automatic csr_access(input logic [1:0] op, input logic [11:0] addr,
                            input logic [31:0] wd, output logic [31:0] rd,
                            output logic ill);
    @(negedge clk);
    csr_op    = op;
    csr_addr  = addr;
    csr_wdata = wd;
    #1;
    rd  = csr_rdata;
    ill = csr_illegal;
    @(posedge clk);
    #1;
    csr_op    = 2'b00;
    csr_wdata = '0;
  endtask

  task automatic csr_read(input logic [11:0] addr, output logic [31:0] rd);
    csr_op   = 2'b00;
    csr_addr = addr;
    #1;
    rd = csr_rdata;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    rst_n      = 1'b0;
    trap_valid = 1'b1;
    trap_cause = 32'h7;
    trap_pc    = 32'h4444;
    mret       = 1'b1;
    irq_ext    = 1'b1;
    csr_op     = 2'b01;
    csr_addr   = 12'h305;
    csr_wdata  = 32'hFFF;
    repeat (2) @(posedge clk);
    #1;
    trap_valid = 1'b0;
    mret       = 1'b0;
    irq_ext    = 1'b0;
    csr_op     = 2'b00;
    csr_wdata  = '0;
    rst_n      = 1'b1;
    csr_read(12'h300, v);
    n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL reset_mstatus: got %h expected %h", v, 32'h0); end
    csr_read(12'h305, v);
    n_checks++; if (v !== 32'h203) begin n_fail++; $display("FAIL reset_mtvec: got %h expected %h", v, 32'h203); end
    csr_read(12'h342, v);
    n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL reset_mcause: got %h expected %h", v, 32'h0); end
    csr_read(12'h344, v);
    n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL reset_mip: got %h expected %h", v, 32'h0); end
    csr_read(12'hB00, v);
    n_checks++; if (v !== 32'h0) begin n_fail++; $display("FAIL reset_mcycle: got %h expected %h", v, 32'h0); end
    n_checks++; if (epc !== 32'h0) begin n_fail++; $display("FAIL reset_epc: got %h expected %h", epc, 32'h0); end
    n_checks++; if (irq_pending !== 1'b0) begin n_fail++; $display("FAIL reset_irq_pending: got %b expected 0", irq_pending); end
    n_checks++; if (trap_vector !== 32'h200) begin n_fail++; $display("FAIL reset_trap_vector: got %h expected %h", trap_vector, 32'h200); end
  endtask

  task automatic test_csr_rw;
    logic [31:0] rd;
    logic        ill;
    csr_access(2'b01, 12'h305, 32'h0000_0101, rd, ill);
    n_checks++; if (rd !== 32'h203) begin n_fail++; $display("FAIL rw_mtvec_old: got %h expected %h", rd, 32'h203); end
    csr_access(2'b10, 12'h300, 32'h8, rd, ill);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rs_mstatus_old: got %h expected %h", rd, 32'h0); end
    csr_read(12'h300, rd);
    n_checks++; if (rd !== 32'h8) begin n_fail++; $display("FAIL mstatus_after_rs: got %h expected %h", rd, 32'h8); end
    csr_read(12'h305, rd);
    n_checks++; if (rd !== 32'h101) begin n_fail++; $display("FAIL mtvec_after_rw: got %h expected %h", rd, 32'h101); end
    n_checks++; if (trap_vector !== 32'h100) begin n_fail++; $display("FAIL tvec_vectored_exc: got %h expected %h", trap_vector, 32'h100); end
    // reserved mode 1x collapses to direct
    csr_access(2'b01, 12'h305, 32'h0000_0302, rd, ill);
    csr_read(12'h305, rd);
    n_checks++; if (rd !== 32'h300) begin n_fail++; $display("FAIL mtvec_mode_legalize: got %h expected %h", rd, 32'h300); end
    csr_access(2'b01, 12'h305, 32'h0000_0101, rd, ill);
    n_checks++; if (rd !== 32'h300) begin n_fail++; $display("FAIL mtvec_restore_old: got %h expected %h", rd, 32'h300); end
    // only MIE/MPIE implemented
    csr_access(2'b01, 12'h300, 32'hFFFF_FFFF, rd, ill);
    csr_read(12'h300, rd);
    n_checks++; if (rd !== 32'h88) begin n_fail++; $display("FAIL mstatus_mask: got %h expected %h", rd, 32'h88); end
    csr_access(2'b11, 12'h300, 32'h80, rd, ill);
    n_checks++; if (rd !== 32'h88) begin n_fail++; $display("FAIL rc_mstatus_old: got %h expected %h", rd, 32'h88); end
    csr_read(12'h300, rd);
    n_checks++; if (rd !== 32'h8) begin n_fail++; $display("FAIL mstatus_after_rc: got %h expected %h", rd, 32'h8); end
    csr_access(2'b01, 12'h304, 32'hFFFF_FFFF, rd, ill);
    csr_read(12'h304, rd);
    n_checks++; if (rd !== 32'h800) begin n_fail++; $display("FAIL mie_mask: got %h expected %h", rd, 32'h800); end
    csr_access(2'b01, 12'h341, 32'h0000_1237, rd, ill);
    n_checks++; if (epc !== 32'h1234) begin n_fail++; $display("FAIL mepc_low_bits: got %h expected %h", epc, 32'h1234); end
  endtask

  task automatic test_trap;
    logic [31:0] rd;
    @(negedge clk);
    trap_valid = 1'b1;
    trap_pc    = 32'h0000_1236;
    trap_cause = 32'd11;
    @(posedge clk);
    #1;
    trap_valid = 1'b0;
    n_checks++; if (epc !== 32'h1234) begin n_fail++; $display("FAIL trap_mepc: got %h expected %h", epc, 32'h1234); end
    csr_read(12'h342, rd);
    n_checks++; if (rd !== 32'd11) begin n_fail++; $display("FAIL trap_mcause: got %h expected %h", rd, 32'd11); end
    csr_read(12'h300, rd);
    n_checks++; if (rd !== 32'h80) begin n_fail++; $display("FAIL trap_mstatus: got %h expected %h", rd, 32'h80); end
    n_checks++; if (trap_vector !== 32'h100) begin n_fail++; $display("FAIL trap_vector_exc: got %h expected %h", trap_vector, 32'h100); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] rd;
    @(negedge clk);
    mret = 1'b1;
    @(posedge clk);
    #1;
    mret = 1'b0;
    csr_read(12'h300, rd);
    n_checks++; if (rd !== 32'h88) begin n_fail++; $display("FAIL mret_mstatus: got %h expected %h", rd, 32'h88); end
    // trap + mret + mepc write together: trap wins
    @(negedge clk);
    trap_valid = 1'b1;
    trap_pc    = 32'h0000_2000;
    trap_cause = 32'd5;
    mret       = 1'b1;
    csr_op     = 2'b01;
    csr_addr   = 12'h341;
    csr_wdata  = 32'hDEAD_0000;
    @(posedge clk);
    #1;
    trap_valid = 1'b0;
    mret       = 1'b0;
    csr_op     = 2'b00;
    csr_wdata  = '0;
    n_checks++; if (epc !== 32'h2000) begin n_fail++; $display("FAIL prio_trap_mepc: got %h expected %h", epc, 32'h2000); end
    csr_read(12'h300, rd);
    n_checks++; if (rd !== 32'h80) begin n_fail++; $display("FAIL prio_trap_mstatus: got %h expected %h", rd, 32'h80); end
    csr_read(12'h342, rd);
    n_checks++; if (rd !== 32'd5) begin n_fail++; $display("FAIL prio_trap_mcause: got %h expected %h", rd, 32'd5); end
    // mret + mstatus write together: mret wins
    @(negedge clk);
    mret      = 1'b1;
    csr_op    = 2'b01;
    csr_addr  = 12'h300;
    csr_wdata = 32'h0;
    @(posedge clk);
    #1;
    mret   = 1'b0;
    csr_op = 2'b00;
    csr_read(12'h300, rd);
    n_checks++; if (rd !== 32'h88) begin n_fail++; $display("FAIL prio_mret_mstatus: got %h expected %h", rd, 32'h88); end
  endtask

  task automatic test_irq_vector;
    logic [31:0] rd;
    @(negedge clk);
    irq_ext = 1'b1;
    #1;
    n_checks++; if (irq_pending !== 1'b0) begin n_fail++; $display("FAIL irq_before_edge: got %b expected 0", irq_pending); end
    @(posedge clk);
    #1;
    n_checks++; if (irq_pending !== 1'b1) begin n_fail++; $display("FAIL irq_after_edge: got %b expected 1", irq_pending); end
    csr_read(12'h344, rd);
    n_checks++; if (rd !== 32'h800) begin n_fail++; $display("FAIL mip_meip: got %h expected %h", rd, 32'h800); end
    @(negedge clk);
    trap_valid = 1'b1;
    trap_pc    = 32'h0000_3000;
    trap_cause = 32'h8000_000B;
    @(posedge clk);
    #1;
    trap_valid = 1'b0;
    n_checks++; if (trap_vector !== 32'h12C) begin n_fail++; $display("FAIL tvec_vectored_irq: got %h expected %h", trap_vector, 32'h12C); end
    n_checks++; if (irq_pending !== 1'b0) begin n_fail++; $display("FAIL irq_masked_in_trap: got %b expected 0", irq_pending); end
    irq_ext = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_illegal;
    logic [31:0] rd;
    logic        ill;
    csr_access(2'b01, 12'h344, 32'hFFFF_FFFF, rd, ill);
    n_checks++; if (ill !== 1'b1) begin n_fail++; $display("FAIL ill_rw_mip: got %b expected 1", ill); end
    csr_read(12'h344, rd);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL mip_unchanged: got %h expected %h", rd, 32'h0); end
    csr_access(2'b10, 12'h344, 32'h0, rd, ill);
    n_checks++; if (ill !== 1'b0) begin n_fail++; $display("FAIL rs0_mip_legal: got %b expected 0", ill); end
    csr_access(2'b11, 12'h344, 32'h800, rd, ill);
    n_checks++; if (ill !== 1'b1) begin n_fail++; $display("FAIL ill_rc_mip: got %b expected 1", ill); end
    csr_access(2'b10, 12'h7C0, 32'h5, rd, ill);
    n_checks++; if (ill !== 1'b1) begin n_fail++; $display("FAIL ill_unimpl: got %b expected 1", ill); end
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL unimpl_rdata: got %h expected %h", rd, 32'h0); end
    csr_access(2'b00, 12'h7C0, 32'h5, rd, ill);
    n_checks++; if (ill !== 1'b0) begin n_fail++; $display("FAIL none_op_legal: got %b expected 0", ill); end
    // illegal write to mtvec region must not leak: mtvec still 0x101
    csr_read(12'h305, rd);
    n_checks++; if (rd !== 32'h101) begin n_fail++; $display("FAIL mtvec_after_illegal: got %h expected %h", rd, 32'h101); end
  endtask

  task automatic test_counter;
    logic [31:0] lo;
    logic [31:0] hi;
    logic        ill;
    csr_access(2'b01, 12'hB80, 32'h0, lo, ill);
    csr_access(2'b01, 12'hB00, 32'hFFFF_FFFF, lo, ill);
    csr_read(12'hB00, lo);
    csr_read(12'hB80, hi);
    n_checks++; if (lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL cyc_wr_lo: got %h expected %h", lo, 32'hFFFF_FFFF); end
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL cyc_hi_zero: got %h expected %h", hi, 32'h0); end
    // writing low half while it is all-ones: no carry into high half
    csr_access(2'b01, 12'hB00, 32'h10, lo, ill);
    csr_read(12'hB00, lo);
    csr_read(12'hB80, hi);
    n_checks++; if (lo !== 32'h10) begin n_fail++; $display("FAIL cyc_rewrite_lo: got %h expected %h", lo, 32'h10); end
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL cyc_no_carry_on_wr: got %h expected %h", hi, 32'h0); end
    @(posedge clk);
    #1;
    csr_read(12'hB00, lo);
    n_checks++; if (lo !== 32'h11) begin n_fail++; $display("FAIL cyc_increment: got %h expected %h", lo, 32'h11); end
    csr_access(2'b01, 12'hB00, 32'hFFFF_FFFF, lo, ill);
    @(posedge clk);
    #1;
    csr_read(12'hB00, lo);
    csr_read(12'hB80, hi);
    n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL cyc_carry_lo: got %h expected %h", lo, 32'h0); end
    n_checks++; if (hi !== 32'h1) begin n_fail++; $display("FAIL cyc_carry_hi: got %h expected %h", hi, 32'h1); end
    // 64-bit wrap
    csr_access(2'b01, 12'hB80, 32'hFFFF_FFFF, lo, ill);
    csr_access(2'b01, 12'hB00, 32'hFFFF_FFFF, lo, ill);
    csr_read(12'hB80, hi);
    n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL cyc_wr_hi: got %h expected %h", hi, 32'hFFFF_FFFF); end
    @(posedge clk);
    #1;
    csr_read(12'hB00, lo);
    csr_read(12'hB80, hi);
    n_checks++; if ({hi, lo} !== 64'h0) begin n_fail++; $display("FAIL cyc_wrap64: got %h expected %h", {hi, lo}, 64'h0); end
    // mid-run reset
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    csr_read(12'hB00, lo);
    csr_read(12'hB80, hi);
    n_checks++; if ({hi, lo} !== 64'h0) begin n_fail++; $display("FAIL cyc_reset: got %h expected %h", {hi, lo}, 64'h0); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    csr_read(12'hB00, lo);
    n_checks++; if (lo !== 32'h1) begin n_fail++; $display("FAIL cyc_after_reset: got %h expected %h", lo, 32'h1); end
  endtask

  initial begin
    rst_n      = 1'b0;
    csr_op     = 2'b00;
    csr_addr   = '0;
    csr_wdata  = '0;
    trap_valid = 1'b0;
    trap_cause = '0;
    trap_pc    = '0;
    mret       = 1'b0;
    irq_ext    = 1'b0;
    test_reset();
    test_csr_rw();
    test_trap();
    test_back_to_back();
    test_irq_vector();
    test_illegal();
    test_counter();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_unit.md
CSR_UNIT -- requirements
Module: csr_unit

Interface
REQ-001 The block SHALL take parameter XLEN, default 32, as the CSR and data width.
REQ-002 The block SHALL take parameter HAS_CYCLE, default 1; when 1, the 64-bit mcycle/mcycleh counter exists.
REQ-003 The block SHALL take parameter MTVEC_RESET, default 0, as the reset value of mtvec.
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit, a synchronous, active-low reset.
REQ-006 The block SHALL have these CSR access ports:
- csr_op, input, 2 bits: 00 none, 01 RW, 10 RS (set), 11 RC (clear).
- csr_addr, input, 12 bits.
- csr_wdata, input, XLEN bits: rs1 value or zero-extended uimm.
- csr_rdata, output, XLEN bits: old CSR value.
- csr_illegal, output, 1 bit: the access is invalid.
REQ-007 The block SHALL have these trap and return ports:
- trap_valid, input, 1 bit: an exception is being taken this cycle.
- trap_cause, input, XLEN bits.
- trap_pc, input, XLEN bits.
- mret, input, 1 bit.
- irq_ext, input, 1 bit: level-sensitive external interrupt.
REQ-008 The block SHALL have these status outputs:
- trap_vector, output, XLEN bits: handler address.
- epc, output, XLEN bits: current mepc.
- irq_pending, output, 1 bit: an interrupt should be taken.

Function
REQ-009 Implemented CSRs SHALL be mstatus 0x300, mie 0x304, mtvec 0x305, mepc 0x341, mcause 0x342 and mip 0x344; mcycle 0xB00 and mcycleh 0xB80 are implemented only when HAS_CYCLE=1.
REQ-010 csr_rdata SHALL be combinational from csr_addr in the same cycle, and 0 for unimplemented addresses.
REQ-011 csr_illegal SHALL be 1 when csr_op≠00 and either the address is unimplemented or the access writes mip.
REQ-012 On an illegal access the block SHALL perform no CSR write.
REQ-013 The new value SHALL be wdata for RW, old|wdata for RS, and old&~wdata for RC, written at the next rising edge.
REQ-014 RS or RC with csr_wdata=0 SHALL perform no write, so it is legal on mip.
REQ-015 Only mstatus bits MIE[3] and MPIE[7] SHALL be implemented; other bits read 0.
REQ-016 Only mie bit MEIE[11] SHALL be implemented.
REQ-017 mepc bits [1:0] SHALL read 0.
REQ-018 mtvec[1:0] SHALL be the mode field: 00 direct, 01 vectored; values 1x write as 00.
REQ-019 mip.MEIP[11] SHALL be irq_ext registered, giving 1 cycle of latency; mip is read-only.
REQ-020 irq_pending SHALL equal mstatus.MIE & mie.MEIE & mip.MEIP.
REQ-021 On trap_valid the block SHALL in one edge set mepc←trap_pc & ~3, mcause←trap_cause, MPIE←MIE and MIE←0.
REQ-022 On mret the block SHALL in one edge set MIE←MPIE and MPIE←1.
REQ-023 trap_vector SHALL be {mtvec[XLEN-1:2],2'b00} in direct mode.
REQ-024 In vectored mode with mcause[XLEN-1]=1, trap_vector SHALL be base+4×mcause[XLEN-2:0]; otherwise it is base.
REQ-025 trap_vector SHALL be computed from the registered mcause.
REQ-026 Simultaneous events SHALL resolve by priority trap_valid > mret > CSR write; a lower-priority event in the same cycle is dropped entirely.
REQ-027 mcycle SHALL increment by 1 every cycle, with the 64-bit value carrying from the low word into mcycleh.
REQ-028 A CSR write to mcycle or mcycleh SHALL replace that half instead of incrementing it that cycle.
REQ-029 When the low half is written, the high half SHALL NOT receive a carry that cycle.
REQ-030 Wrap from 2^64-1 SHALL go to 0.

Reset
REQ-031 While rst_n=0 at a rising edge the block SHALL load: mstatus=0, mie=0, mtvec=MTVEC_RESET, mepc=0, mcause=0, mip=0, mcycle=0.
REQ-032 Reset SHALL override trap_valid, mret and CSR writes in the same cycle.
REQ-033 Immediately after reset, irq_pending=0 and trap_vector=MTVEC_RESET & ~3.

Structure
REQ-034 Package csr_pkg SHALL hold the CSR address constants, the csr_op encodings, the mstatus/mie/mip bit indices and the mtvec mode values.
REQ-035 The 64-bit counter SHALL be sub-module csr_counter, with inputs clk, rst_n, wr_lo, wr_hi and wdata, and a 64-bit output.

Verification
REQ-036 Scenario: RW 0x305 with 0x0000_0101, then RS 0x300 with 0x8 -> mtvec=0x100 (mode 01); mstatus reads 0x8; csr_rdata of each access returns the prior value.
REQ-037 Scenario: trap_valid with trap_pc=0x0000_1236 and cause=11, MIE=1 -> mepc=0x1234, mcause=11, mstatus=0x80, trap_vector=0x100.
REQ-038 Scenario: mret after the trap above -> mstatus=0x88; trap_valid and mret plus an RW write of mepc in the same cycle -> only the trap takes effect.
REQ-039 Scenario: MIE=1, MEIE=1, irq_ext rises -> irq_pending=1 exactly one cycle later; vectored mode with mcause=0x8000_000B -> trap_vector=0x12C.
REQ-040 Scenario: RW 0x344 -> csr_illegal=1 and mip is unchanged; any op to 0x7C0 -> csr_illegal=1 and rdata=0.
REQ-041 Scenario: write mcycle=0xFFFF_FFFF with mcycleh=0 -> next cycle reads mcycle=0 and mcycleh=1; rst_n=0 mid-run clears the counter to 0.
